// File: rtl/sc_road_pkg.sv
// -----------------------------------------------------------------------------
// sc_road_pkg
// Shared definitions for the RoadFighter road-matrix scroller:
//   - state_t            : scroller state machine encoding (IDLE, SCROLL, CRASH)
//   - LFSR_WIDTH         : obstacle generator LFSR width (16)
//   - LFSR_TAP_MASK      : feedback taps for x^16+x^14+x^13+x^11+1
//                          (fb = l[0]^l[2]^l[3]^l[5], shift right, fb enters at MSB)
//   - LFSR_DEFAULT_SEED  : default non-zero seed 16'hACE1
//   - lfsr_next()        : one Fibonacci step of the LFSR
// -----------------------------------------------------------------------------
package sc_road_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCROLL = 2'd1,
      CRASH  = 2'd2
   } state_t;

   localparam int          LFSR_WIDTH        = 16;
   localparam logic [15:0] LFSR_TAP_MASK     = 16'h002D;   // bits 0,2,3,5
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   // One step: feedback is the XOR of the tapped bits, inserted at the MSB.
   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      logic fb;
      fb = ^(l & LFSR_TAP_MASK);
      return {fb, l[15:1]};
   endfunction

endpackage

// File: rtl/sc_road_lfsr.sv
// -----------------------------------------------------------------------------
// sc_road_lfsr
// 16-bit Fibonacci LFSR feeding the obstacle column choice. Only the low
// OUT_W bits are exported; the full state stays inside.
// Ports:
//   i_clk   : clock
//   i_rst   : asynchronous active-high reset (loads SEED)
//   i_load  : synchronous load of SEED (has priority over i_step)
//   i_step  : advance one step
//   o_low   : low OUT_W bits of the current LFSR state
// -----------------------------------------------------------------------------
module sc_road_lfsr
   import sc_road_pkg::*;
#(
   parameter logic [15:0] SEED  = LFSR_DEFAULT_SEED,
   parameter int          OUT_W = 3
)
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_step,
   output logic [OUT_W-1:0] o_low
);

   logic [15:0] r_lfsr;

   // LFSR state register: seed on reset/load, one step per enable.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_lfsr <= SEED;
      end else if (i_load) begin
         r_lfsr <= SEED;
      end else if (i_step) begin
         r_lfsr <= lfsr_next(r_lfsr);
      end else begin
         r_lfsr <= r_lfsr;
      end
   end

   assign o_low = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/sc_road_scroller.sv
// -----------------------------------------------------------------------------
// sc_road_scroller
// Scrolls an obstacle matrix down one row per speed tick, inserting a new top
// row from an LFSR-driven generator (GAP_ROWS empty rows between obstacle
// rows). Compares the bottom row with the car column and latches a sticky
// crash flag. All outputs are registered.
//
// Optional feature macro: SC_ROADSCROLL_CARMERGE_EN
//   defined     : matrix output bottom row shows obstacles | car
//   not defined : matrix output shows obstacles only
//   Collision always uses the obstacle-only matrix.
//
// Ports:
//   SC_RoadSCROLL_CLOCK_50        : clock
//   SC_RoadSCROLL_RESET_InHigh    : asynchronous active-high reset
//   SC_RoadSCROLL_clear_InHigh    : synchronous clear to the reset state
//   SC_RoadSCROLL_run_InHigh      : 1 = scroll allowed, 0 = pause
//   SC_RoadSCROLL_tick_InHigh     : one-cycle speed pulse
//   SC_RoadSCROLL_car_InBUS       : one-hot car column on the bottom row
//   SC_RoadSCROLL_matrix_OutBUS   : row r at [r*COLS +: COLS], row 0 on top
//   SC_RoadSCROLL_crash_OutHigh   : sticky crash flag
//   SC_RoadSCROLL_rowcount_OutBUS : rows scrolled since clear, saturating 255
// -----------------------------------------------------------------------------
module sc_road_scroller
   import sc_road_pkg::*;
#(
   parameter int          ROWS      = 8,
   parameter int          COLS      = 8,
   parameter int          GAP_ROWS  = 2,
   parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED
)
(
   input  logic                 SC_RoadSCROLL_CLOCK_50,
   input  logic                 SC_RoadSCROLL_RESET_InHigh,
   input  logic                 SC_RoadSCROLL_clear_InHigh,
   input  logic                 SC_RoadSCROLL_run_InHigh,
   input  logic                 SC_RoadSCROLL_tick_InHigh,
   input  logic [COLS-1:0]      SC_RoadSCROLL_car_InBUS,
   output logic [ROWS*COLS-1:0] SC_RoadSCROLL_matrix_OutBUS,
   output logic                 SC_RoadSCROLL_crash_OutHigh,
   output logic [7:0]           SC_RoadSCROLL_rowcount_OutBUS
);

   localparam int COL_W = (COLS < 2) ? 1 : $clog2(COLS);
   localparam int GAP_W = (GAP_ROWS < 1) ? 1 : $clog2(GAP_ROWS + 1);
   localparam int MAT_W = ROWS * COLS;

   state_t               r_state;
   logic [MAT_W-1:0]     r_matrix;
   logic                 r_crash;
   logic [7:0]           r_rowcount;
   logic [GAP_W-1:0]     r_gapcnt;

   state_t               w_fsm_nxt;
   state_t               w_state_nxt;
   logic                 w_shift;
   logic                 w_collision;
   logic [COLS-1:0]      w_bottom;
   logic [COLS-1:0]      w_new_row;
   logic [COL_W-1:0]     w_lfsr_col;
   logic [MAT_W-1:0]     w_matrix_nxt;
   logic [7:0]           w_rowcount_nxt;
   logic [GAP_W-1:0]     w_gapcnt_nxt;
   logic                 w_lfsr_load;
   logic                 w_lfsr_step;

   // Collision is judged on the registered obstacle matrix only.
   assign w_bottom    = r_matrix[(ROWS-1)*COLS +: COLS];
   assign w_collision = |(w_bottom & SC_RoadSCROLL_car_InBUS);

   // A clear wins over any shift; the LFSR reloads its seed instead.
   assign w_lfsr_load = SC_RoadSCROLL_clear_InHigh;
   assign w_lfsr_step = w_shift & ~SC_RoadSCROLL_clear_InHigh;

   sc_road_lfsr #(
      .SEED  (LFSR_SEED),
      .OUT_W (COL_W)
   ) u_lfsr (
      .i_clk  (SC_RoadSCROLL_CLOCK_50),
      .i_rst  (SC_RoadSCROLL_RESET_InHigh),
      .i_load (w_lfsr_load),
      .i_step (w_lfsr_step),
      .o_low  (w_lfsr_col)
   );

   // FSM next state and shift request: collision > pause > tick.
   always_comb begin
      w_fsm_nxt = r_state;
      w_shift   = 1'b0;
      case (r_state)
         IDLE: begin
            if (SC_RoadSCROLL_run_InHigh) begin
               w_fsm_nxt = SCROLL;
            end else begin
               w_fsm_nxt = IDLE;
            end
         end
         SCROLL: begin
            if (w_collision) begin
               w_fsm_nxt = CRASH;
            end else if (!SC_RoadSCROLL_run_InHigh) begin
               w_fsm_nxt = IDLE;
            end else begin
               w_fsm_nxt = SCROLL;
               w_shift   = SC_RoadSCROLL_tick_InHigh;
            end
         end
         CRASH: begin
            w_fsm_nxt = CRASH;
         end
         default: begin
            w_fsm_nxt = IDLE;
         end
      endcase
   end

   // New top row: empty while the gap counter runs, else one-hot at the LFSR
   // column taken from the pre-shift LFSR value.
   always_comb begin
      w_new_row    = {COLS{1'b0}};
      w_gapcnt_nxt = r_gapcnt;
      if (r_gapcnt < GAP_W'(GAP_ROWS)) begin
         w_new_row    = {COLS{1'b0}};
         w_gapcnt_nxt = r_gapcnt + GAP_W'(1);
      end else begin
         w_new_row    = COLS'(1) << w_lfsr_col;
         w_gapcnt_nxt = {GAP_W{1'b0}};
      end
   end

   // Datapath next values, with clear overriding everything.
   always_comb begin
      w_state_nxt    = w_fsm_nxt;
      w_matrix_nxt   = r_matrix;
      w_rowcount_nxt = r_rowcount;
      if (SC_RoadSCROLL_clear_InHigh) begin
         w_state_nxt    = IDLE;
         w_matrix_nxt   = {MAT_W{1'b0}};
         w_rowcount_nxt = 8'd0;
      end else if (w_shift) begin
         w_matrix_nxt   = {r_matrix[(ROWS-1)*COLS-1:0], w_new_row};
         w_rowcount_nxt = (r_rowcount == 8'hFF) ? 8'hFF : (r_rowcount + 8'd1);
      end else begin
         w_matrix_nxt   = r_matrix;
         w_rowcount_nxt = r_rowcount;
      end
   end

   // State, matrix, counters and crash flag registers.
   always_ff @(posedge SC_RoadSCROLL_CLOCK_50 or posedge SC_RoadSCROLL_RESET_InHigh) begin
      if (SC_RoadSCROLL_RESET_InHigh) begin
         r_state    <= IDLE;
         r_matrix   <= {MAT_W{1'b0}};
         r_rowcount <= 8'd0;
         r_gapcnt   <= {GAP_W{1'b0}};
         r_crash    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_matrix   <= w_matrix_nxt;
         r_rowcount <= w_rowcount_nxt;
         r_crash    <= (w_state_nxt == CRASH);
         if (SC_RoadSCROLL_clear_InHigh) begin
            r_gapcnt <= {GAP_W{1'b0}};
         end else if (w_shift) begin
            r_gapcnt <= w_gapcnt_nxt;
         end else begin
            r_gapcnt <= r_gapcnt;
         end
      end
   end

`ifdef SC_ROADSCROLL_CARMERGE_EN
   logic [MAT_W-1:0] r_disp;
   logic [MAT_W-1:0] w_car_mask;

   // Car sits on the bottom row, which occupies the top bits of the bus.
   assign w_car_mask = {SC_RoadSCROLL_car_InBUS, {((ROWS-1)*COLS){1'b0}}};

   // Display copy of the matrix with the car overlaid.
   always_ff @(posedge SC_RoadSCROLL_CLOCK_50 or posedge SC_RoadSCROLL_RESET_InHigh) begin
      if (SC_RoadSCROLL_RESET_InHigh) begin
         r_disp <= {MAT_W{1'b0}};
      end else if (SC_RoadSCROLL_clear_InHigh) begin
         r_disp <= {MAT_W{1'b0}};
      end else begin
         r_disp <= w_matrix_nxt | w_car_mask;
      end
   end

   assign SC_RoadSCROLL_matrix_OutBUS = r_disp;
`else
   assign SC_RoadSCROLL_matrix_OutBUS = r_matrix;
`endif

   assign SC_RoadSCROLL_crash_OutHigh   = r_crash;
   assign SC_RoadSCROLL_rowcount_OutBUS = r_rowcount;

endmodule

// File: doc/sc_road_scroller.md
# sc_road_scroller

Road-matrix scroller for the RoadFighter display path, directly downstream of the speed/time tick counter. Each speed tick from the counter shifts an 8×8 obstacle matrix down one row and inserts a new top row from an LFSR-driven obstacle generator. It checks the bottom row against the player car position and latches a sticky crash flag. Its matrix output feeds the LED-matrix driver.

## Interface
- `ROWS`, default 8: matrix rows. Row 0 is the top row; row ROWS-1 is the car row.
- `COLS`, default 8: matrix columns. Must be a power of two, 2..16.
- `GAP_ROWS`, default 2: number of empty rows inserted between obstacle rows.
- `LFSR_SEED`, default 16'hACE1: LFSR value loaded on reset and on clear. Must be non-zero.

Ports:
- `SC_RoadSCROLL_CLOCK_50`, in, 1: system clock.
- `SC_RoadSCROLL_RESET_InHigh`, in, 1: reset, asynchronous, active-high.
- `SC_RoadSCROLL_clear_InHigh`, in, 1: synchronous clear, back to the reset state.
- `SC_RoadSCROLL_run_InHigh`, in, 1: level input; 1 allows scrolling, 0 pauses.
- `SC_RoadSCROLL_tick_InHigh`, in, 1: one-cycle speed pulse from the upstream time counter.
- `SC_RoadSCROLL_car_InBUS`, in, COLS: one-hot car column on the bottom row. All-zero means no car.
- `SC_RoadSCROLL_matrix_OutBUS`, out, ROWS*COLS: row r occupies bits [r*COLS +: COLS].
- `SC_RoadSCROLL_crash_OutHigh`, out, 1: sticky crash flag.
- `SC_RoadSCROLL_rowcount_OutBUS`, out, 8: rows scrolled since clear, saturating at 255.

## Operation
- **State machine states:** IDLE, SCROLL, CRASH. Reset and clear force IDLE.
- **IDLE:** if run=1, go to SCROLL on the next edge. Ticks are ignored in IDLE.
- **SCROLL:**
  - If run=0, return to IDLE (pause). Matrix, LFSR and counters are held.
  - Collision = |(bottom row & car), evaluated every cycle on the registered matrix. Collision → CRASH, crash=1.
  - Otherwise, if tick=1, perform a shift: row r ← row r-1, row 0 ← new row, rowcount += 1 (saturating).
- **CRASH:** everything is frozen, and crash stays 1 until clear or reset.
- **New row generation (on each shift):**
  - If gapcnt < GAP_ROWS: new row = 0 and gapcnt += 1.
  - Otherwise: new row = one-hot at column lfsr[log2(COLS)-1:0] and gapcnt = 0.
  - The row uses the LFSR value held before the shift. The LFSR advances once per shift.
- **LFSR:** 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - fb = l[0]^l[2]^l[3]^l[5].
  - l ← {fb, l[15:1]}.
- **Priorities:**
  - reset > clear > collision > run=0 > tick.
  - Tick coincident with collision: no shift.
  - Tick coincident with clear: cleared, no shift.
- **Width rules:** gapcnt is wide enough to hold GAP_ROWS. rowcount saturates: 255 + shift = 255.
- **Reset/clear values:** matrix 0, crash 0, rowcount 0, gapcnt 0, LFSR = LFSR_SEED, state IDLE.

## Timing
- All outputs are registered.
- Shift latency: matrix updates at the first edge after the tick is sampled high in SCROLL.
- run rising: one cycle IDLE→SCROLL. A tick in that same cycle is lost.
- Collision latency: crash rises one edge after the colliding bottom row or car value is present.
- Car moving into an obstacle with no tick still crashes, with the same one-cycle latency.
- Asynchronous reset mid-scroll immediately zeroes all outputs.
- Back-to-back ticks on consecutive cycles each shift once.

## Configuration
- `SC_ROADSCROLL_CARMERGE_EN`:
  - Defined: matrix_OutBUS bottom row = obstacles | car, so the LED driver shows the car.
  - Not defined: matrix_OutBUS shows obstacles only.
- Collision logic always uses the obstacle-only matrix.

## Structure
- Package `sc_road_pkg`:
  - state enum (IDLE, SCROLL, CRASH);
  - LFSR tap constants;
  - default seed 16'hACE1.
- Sub-module `sc_road_lfsr`: 16-bit LFSR with load (seed) and step enables.
- The scroller instantiates `sc_road_lfsr` once. The matrix shift, gap counter, FSM and collision logic stay in the top module.

## Test plan
- Reset, run=1, car=0, three ticks → row0=8'h01, rows1..7=0, rowcount=3. LFSR sequence is ACE1→5670→AB38; row uses AB38[2:0]=0.
- Continue from the above, car=8'h01, seven more ticks (total 10) → obstacle reaches row7. crash=1 one cycle after the 10th shift. rowcount=10, then frozen; further ticks produce no change.
- Tick in the same cycle as clear, in SCROLL → matrix 0, rowcount 0, LFSR=ACE1, state IDLE.
- run=0 after 5 ticks, then 4 ticks → matrix and rowcount unchanged at 5. run=1 plus one tick → rowcount=6.
- Assert reset mid-run asynchronously, between clock edges → all outputs 0 before the next clock edge.
- Tick 300 times, car=0 → rowcount saturates at 255. Obstacle rows always separated by exactly 2 empty rows.
